// File: rtl/mem_responder_if.sv
// Request/response bus between an L1 cache (master) and the backing memory
// (slave): one request per cycle, in-order read returns.
interface mem_responder_if;
   logic        o_mem_ready;
   logic [31:0] i_mem_addr;
   logic        i_mem_ren;
   logic        i_mem_wen;
   logic [31:0] i_mem_wdata;
   logic [31:0] o_mem_rdata;
   logic        o_mem_valid;

   modport master (
      input  o_mem_ready, o_mem_rdata, o_mem_valid,
      output i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata
   );

   modport slave (
      output o_mem_ready, o_mem_rdata, o_mem_valid,
      input  i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata
   );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed backing memory behind the L1 caches. Reads return in order
// after a fixed pipelined latency; ready drops when too many reads are
// outstanding or for one injected stall cycle every STALL_PERIOD accepts.
module mem_responder #(
   parameter int ADDR_W          = 10,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_PERIOD    = 0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mem_responder_if.slave bus
);
   localparam int IW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [IW-1:0] MAX_C = IW'(MAX_OUTSTANDING);

   logic [31:0]               mem [2**ADDR_W];
   logic [LATENCY-1:0]        vld_pipe;
   logic [LATENCY-1:0][31:0]  data_pipe;
   logic [IW-1:0]             inflight;
   logic                      stall_cycle;
   logic [ADDR_W-1:0]         idx;
   logic                      accept, rd_acc, wr_acc, retire;
   logic                      unused_addr;

   // Byte address -> word index; low byte bits and high bits alias away.
   assign idx         = bus.i_mem_addr[ADDR_W+1:2];
   assign unused_addr = ^{bus.i_mem_addr[1:0], bus.i_mem_addr[31:ADDR_W+2]};

   // Ready depends on registered state and reset only, never on the request.
   assign bus.o_mem_ready = i_rst_n & (inflight < MAX_C) & ~stall_cycle;

   // ren+wen together is treated as a plain write.
   assign accept = bus.o_mem_ready & (bus.i_mem_ren | bus.i_mem_wen);
   assign wr_acc = accept & bus.i_mem_wen;
   assign rd_acc = accept & bus.i_mem_ren & ~bus.i_mem_wen;
   assign retire = vld_pipe[LATENCY-1];

   assign bus.o_mem_valid = vld_pipe[LATENCY-1];
   assign bus.o_mem_rdata = vld_pipe[LATENCY-1] ? data_pipe[LATENCY-1] : '0;

   // Storage: contents survive reset on purpose.
   always_ff @(posedge i_clk) begin
      if (wr_acc) mem[idx] <= bus.i_mem_wdata;
   end

   // Read pipeline: data is captured at the accepting edge, so later writes
   // cannot disturb a read already in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_pipe  <= '0;
         data_pipe <= '0;
      end else begin
         vld_pipe[0]  <= rd_acc;
         data_pipe[0] <= rd_acc ? mem[idx] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
         end
      end
   end

   // Outstanding reads: +1 on read accept, -1 as a valid cycle ends.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         inflight <= '0;
      end else if (rd_acc && !retire) begin
         inflight <= inflight + 1'b1;
      end else if (!rd_acc && retire) begin
         inflight <= inflight - 1'b1;
      end
   end

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
         logic [SW-1:0] stall_cnt;

         // Count accepts; the one that completes a period stalls the next cycle.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               stall_cnt   <= '0;
               stall_cycle <= 1'b0;
            end else begin
               stall_cycle <= 1'b0;
               if (accept) begin
                  if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
                     stall_cnt   <= '0;
                     stall_cycle <= 1'b1;
                  end else begin
                     stall_cnt <= stall_cnt + 1'b1;
                  end
               end
            end
         end
      end else begin : g_nostall
         assign stall_cycle = 1'b0;
      end
   endgenerate
endmodule
